// File: rtl/prach_fft3_sched.sv
// rtl/prach_fft3_sched.sv - round-robin frame scheduler feeding one radix-3 FFT pipeline
// Grants one PRACH channel per frame, streams FFT_LEN samples, then idles GUARD cycles.
module prach_fft3_sched #(
  parameter int NUM_CH  = 4,
  parameter int FFT_LEN = 864,
  parameter int GUARD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_CH*18-1:0]      s_dr,
  input  logic [NUM_CH*18-1:0]      s_di,
  input  logic [NUM_CH-1:0]         s_valid,
  output logic [NUM_CH-1:0]         s_ready,
  output logic [17:0]               dout_dr,
  output logic [17:0]               dout_di,
  output logic                      dout_dv,
  output logic                      sync_out,
  output logic [$clog2(NUM_CH)-1:0] dout_ch,
  output logic                      busy,
  output logic                      frame_done
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FFT_LEN);
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state, state_nx;

  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  req_idx;
  logic [CH_W-1:0]  cand;
  logic             req_found;
  logic             grant;
  logic             xfer;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [17:0]      dr_arr [NUM_CH];
  logic [17:0]      di_arr [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      dr_arr[k] = s_dr[k*18 +: 18];
      di_arr[k] = s_di[k*18 +: 18];
    end
  end

  // Search starts just after the last granted channel so every requester gets a turn.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!req_found && s_valid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = RUN;
      RUN:     if (xfer && last) state_nx = (GUARD == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_W'(GUARD)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready = '0;
    if (state == RUN) s_ready[dout_ch] = 1'b1;
    xfer  = (state == RUN) && s_valid[dout_ch];
    grant = (state == IDLE) && en && req_found;
    last  = (cnt == CNT_W'(FFT_LEN - 1));
  end

  // gap_cnt runs through 0..GUARD in GAP; the first GAP cycle still carries the last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= CH_W'(NUM_CH - 1);
      dout_ch    <= '0;
      cnt        <= '0;
      gap_cnt    <= '0;
      dout_dr    <= '0;
      dout_di    <= '0;
      dout_dv    <= 1'b0;
      sync_out   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_dv    <= xfer;
      sync_out   <= xfer && (cnt == '0);
      frame_done <= xfer && last;
      if (grant) begin
        dout_ch <= req_idx;
        rr_ptr  <= req_idx;
        cnt     <= '0;
      end
      if (xfer) begin
        dout_dr <= dr_arr[dout_ch];
        dout_di <= di_arr[dout_ch];
        cnt     <= cnt + 1'b1;
      end
      if (state == RUN) gap_cnt <= '0;
      else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_prach_fft3_sched.sv
// tb/tb_prach_fft3_sched.sv - scoreboard bench for the PRACH radix-3 frame scheduler
// Per-channel sources advance on handshake; expected frames are queued as stimulus is set up.
module tb_prach_fft3_sched;
  localparam int NUM_CH  = 4;
  localparam int FFT_LEN = 6;
  localparam int GUARD   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [NUM_CH*18-1:0] s_dr;
  logic [NUM_CH*18-1:0] s_di;
  logic [NUM_CH-1:0]    s_valid = '0;
  logic [NUM_CH-1:0]    s_ready;
  logic [17:0]          dout_dr;
  logic [17:0]          dout_di;
  logic                 dout_dv;
  logic                 sync_out;
  logic [1:0]           dout_ch;
  logic                 busy;
  logic                 frame_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int mode      = 0;
  int src_idx [NUM_CH];
  int exp_idx [NUM_CH];

  typedef struct {
    logic [17:0] dr;
    logic [17:0] di;
    logic [1:0]  ch;
    logic        sync;
    logic        fd;
  } smp_t;

  smp_t        exp_q [$];
  logic [17:0] cap_r [$];
  logic [17:0] cap_i [$];

  prach_fft3_sched #(.NUM_CH(NUM_CH), .FFT_LEN(FFT_LEN), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s_dr(s_dr), .s_di(s_di), .s_valid(s_valid),
    .s_ready(s_ready), .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
    .sync_out(sync_out), .dout_ch(dout_ch), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Mode 0: ramp real part, channel tag in imag. Mode 1: radix-3 triple (5,0),(3,1),(7,-2).
  function automatic logic [17:0] src_re(int m, int k, int n);
    if (m == 1) begin
      if (n % 3 == 0) return 18'd5;
      if (n % 3 == 1) return 18'd3;
      return 18'd7;
    end
    return 18'(n + 1);
  endfunction

  function automatic logic [17:0] src_im(int m, int k, int n);
    if (m == 1) begin
      if (n % 3 == 0) return 18'd0;
      if (n % 3 == 1) return 18'd1;
      return 18'(-2);
    end
    return 18'(-(k + 1));
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      s_dr[k*18 +: 18] = src_re(mode, k, src_idx[k]);
      s_di[k*18 +: 18] = src_im(mode, k, src_idx[k]);
    end
  end

  task automatic push_frame(input int k);
    smp_t e;
    for (int n = 0; n < FFT_LEN; n++) begin
      e.dr   = src_re(mode, k, exp_idx[k] + n);
      e.di   = src_im(mode, k, exp_idx[k] + n);
      e.ch   = 2'(k);
      e.sync = (n == 0);
      e.fd   = (n == FFT_LEN - 1);
      exp_q.push_back(e);
    end
    exp_idx[k] += FFT_LEN;
  endtask

  // One clock: sources advance on handshake, then the scoreboard consumes any output sample.
  task automatic tick();
    logic [NUM_CH-1:0] hs;
    smp_t e;
    hs = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_CH; k++) if (hs[k]) src_idx[k]++;
    @(negedge clk);
    total_cnt++;
    if (dout_dv) begin
      cap_r.push_back(dout_dr);
      cap_i.push_back(dout_di);
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got dr=%0h di=%0h ch=%0d, expected no sample", dout_dr, dout_di, dout_ch);
      end else begin
        e = exp_q.pop_front();
        if ({dout_dr, dout_di, dout_ch, sync_out, frame_done} !== {e.dr, e.di, e.ch, e.sync, e.fd})
          $display("FAIL sb_sample: got dr=%0h di=%0h ch=%0d sync=%0b fd=%0b, expected dr=%0h di=%0h ch=%0d sync=%0b fd=%0b",
                   dout_dr, dout_di, dout_ch, sync_out, frame_done, e.dr, e.di, e.ch, e.sync, e.fd);
        else pass_cnt++;
      end
    end else begin
      if ({sync_out, frame_done} !== 2'b00)
        $display("FAIL idle_flags: got sync=%0b fd=%0b, expected 0 0 without dout_dv", sync_out, frame_done);
      else pass_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    s_valid = '0;
    mode    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      src_idx[k] = 0;
      exp_idx[k] = 0;
    end
    exp_q.delete();
    cap_r.delete();
    cap_i.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < budget) begin
      tick();
      t++;
    end
    total_cnt++;
    if (exp_q.size() != 0 || busy)
      $display("FAIL %s_drain: got %0d pending samples busy=%0b, expected 0 and idle", name, exp_q.size(), busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [45:0] v;
    do_reset();
    rst_n = 1'b0;
    s_valid = '1;
    #1;
    v = {dout_dr, dout_di, dout_dv, sync_out, frame_done, dout_ch, busy, s_ready};
    total_cnt++;
    if (v !== 46'd0) $display("FAIL reset_outputs: got %0h, expected 0", v);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({busy, s_ready} !== 5'd0) $display("FAIL en_low_no_grant: got busy=%0b ready=%0b, expected 0 0", busy, s_ready);
    else pass_cnt++;
    s_valid = '0;
  endtask

  task automatic test_single_frame();
    int t = 0;
    do_reset();
    s_valid = 4'b0100;
    en = 1'b1;
    push_frame(2);
    while (!dout_dv && t < 20) begin tick(); t++; end
    total_cnt++;
    if (!dout_dv) $display("FAIL single_start: got no dout_dv, expected frame within 20 cycles");
    else pass_cnt++;
    en = 1'b0;
    for (int i = 1; i < FFT_LEN; i++) begin
      tick();
      total_cnt++;
      if (dout_dv !== 1'b1) $display("FAIL single_consecutive: got dv=%0b at sample %0d, expected 1", dout_dv, i + 1);
      else pass_cnt++;
    end
    for (int g = 0; g < GUARD; g++) begin
      tick();
      total_cnt++;
      if ({dout_dv, busy} !== 2'b01) $display("FAIL single_guard: got dv=%0b busy=%0b, expected 0 1", dout_dv, busy);
      else pass_cnt++;
    end
    tick();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL single_idle: got busy=%0b, expected 0", busy);
    else pass_cnt++;
    s_valid = '0;
    drain("single", 5);
  endtask

  task automatic test_round_robin();
    int syncs = 0;
    int t = 0;
    do_reset();
    s_valid = '1;
    en = 1'b1;
    push_frame(0); push_frame(1); push_frame(2); push_frame(3); push_frame(0);
    while ((exp_q.size() != 0 || busy) && t < 200) begin
      tick();
      t++;
      if (sync_out) syncs++;
      if (syncs >= 5) en = 1'b0;
      if (s_ready != '0) begin
        total_cnt++;
        if ((s_ready & ~(4'b0001 << dout_ch)) !== 4'b0000)
          $display("FAIL rr_ready_onehot: got ready=%b ch=%0d, expected only granted bit", s_ready, dout_ch);
        else pass_cnt++;
      end
    end
    s_valid = '0;
    drain("rr", 5);
  endtask

  task automatic test_bubbles();
    logic [8:0] pat = 9'b111011001;
    do_reset();
    en = 1'b1;
    s_valid = 4'b0010;
    push_frame(1);
    tick();
    for (int i = 0; i < 9; i++) begin
      s_valid[1] = pat[i];
      tick();
      total_cnt++;
      if (dout_dv !== pat[i]) $display("FAIL bubble_dv: got dv=%0b at step %0d, expected %0b", dout_dv, i, pat[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (frame_done !== 1'b1) $display("FAIL bubble_frame_done: got %0b, expected 1 on 6th transfer", frame_done);
    else pass_cnt++;
    s_valid = '0;
    en = 1'b0;
    drain("bubble", 10);
  endtask

  task automatic test_en_drop();
    int seen = 0;
    int t = 0;
    do_reset();
    s_valid = 4'b0011;
    en = 1'b1;
    push_frame(0);
    while (seen < 3 && t < 30) begin
      tick();
      t++;
      if (dout_dv) seen++;
    end
    en = 1'b0;
    drain("en_drop_frame", 30);
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if ({busy, dout_dv} !== 2'b00) $display("FAIL en_drop_hold: got busy=%0b dv=%0b, expected no grant", busy, dout_dv);
      else pass_cnt++;
    end
    en = 1'b1;
    push_frame(1);
    t = 0;
    while (!dout_dv && t < 20) begin tick(); t++; end
    en = 1'b0;
    drain("en_drop_next", 30);
    s_valid = '0;
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    int t = 0;
    logic [45:0] v;
    do_reset();
    s_valid = 4'b1000;
    en = 1'b1;
    push_frame(3);
    while (seen < 4 && t < 30) begin
      tick();
      t++;
      if (dout_dv) seen++;
    end
    rst_n = 1'b0;
    #1;
    v = {dout_dr, dout_di, dout_dv, sync_out, frame_done, dout_ch, busy, s_ready};
    total_cnt++;
    if (v !== 46'd0) $display("FAIL midreset_outputs: got %0h, expected 0", v);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != FFT_LEN - 4) $display("FAIL midreset_count: got %0d pending, expected %0d", exp_q.size(), FFT_LEN - 4);
    else pass_cnt++;
    exp_q.delete();
    s_valid = '1;
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(0);
    t = 0;
    while (!dout_dv && t < 20) begin tick(); t++; end
    en = 1'b0;
    drain("midreset", 30);
    s_valid = '0;
  endtask

  task automatic test_butterfly();
    int syncs = 0;
    int t = 0;
    logic signed [17:0] x0r, x0i, x1r, x1i, x2r, x2i, y1r, y1i, y2r, y2i;
    do_reset();
    mode = 1;
    s_valid = 4'b0111;
    en = 1'b1;
    push_frame(0); push_frame(1); push_frame(2);
    while ((exp_q.size() != 0 || busy) && t < 120) begin
      tick();
      t++;
      if (sync_out) syncs++;
      if (syncs >= 3) en = 1'b0;
    end
    s_valid = '0;
    drain("bfly", 5);
    total_cnt++;
    if (cap_r.size() != 3 * FFT_LEN) $display("FAIL bfly_count: got %0d samples, expected %0d", cap_r.size(), 3 * FFT_LEN);
    else pass_cnt++;
    for (int g = 0; g + 2 < cap_r.size(); g += 3) begin
      x0r = cap_r[g];     x0i = cap_i[g];
      x1r = cap_r[g + 1]; x1i = cap_i[g + 1];
      x2r = cap_r[g + 2]; x2i = cap_i[g + 2];
      y1r = x1r + x2r; y1i = x1i + x2i;
      y2r = x2r - x1r; y2i = x2i - x1i;
      total_cnt++;
      if ({x0r, x0i} !== {18'sd5, 18'sd0}) $display("FAIL bfly_y0: got (%0d,%0d), expected (5,0)", x0r, x0i);
      else pass_cnt++;
      total_cnt++;
      if ({y1r, y1i} !== {18'sd10, -18'sd1}) $display("FAIL bfly_y1: got (%0d,%0d), expected (10,-1)", y1r, y1i);
      else pass_cnt++;
      total_cnt++;
      if ({y2r, y2i} !== {18'sd4, -18'sd3}) $display("FAIL bfly_y2: got (%0d,%0d), expected (4,-3)", y2r, y2i);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      src_idx[k] = 0;
      exp_idx[k] = 0;
    end
    test_reset();
    test_single_frame();
    test_round_robin();
    test_bubbles();
    test_en_drop();
    test_reset_mid_frame();
    test_butterfly();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1);
  end
endmodule
